mpmc11_chan_arbiter_fta: RTL and testbench
==========================================

# mpmc11_chan_arbiter_fta

Round-robin arbiter that shares the single mpmc11 command path between NCH FTA request channels. Each channel presents a first-word-fall-through command FIFO head. The arbiter pops exactly one command per memory transaction and holds it stable on `fifo_out`/`fifo_v` for the mpmc11 state machine. It sits between the per-channel input FIFOs and the state machine, and is paced by the state machine's `select_next` (high only in IDLE).

## Interface
- `NCH`, 8 — number of request channels, 2..16
- `CHW`, $clog2(NCH) — channel index width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ch_v`  in  NCH  channel FIFO non-empty (head valid)
- `ch_req`  in  NCH × fta_cmd_request256_t  channel FIFO head
- `ch_en`  in  NCH  per-channel enable; 0 = excluded from arbitration
- `ch_rd`  out  NCH  one-hot pop strobe, one cycle
- `select_next`  in  1  state machine ready for next command
- `fifo_out`  out  fta_cmd_request256_t  granted command, registered
- `fifo_v`  out  1  granted command valid
- `gnt_ch`  out  CHW  index of the current or last granted channel
- `busy`  out  1  a command is held or in service

## Operation
- Eligible set: `E = ch_v & ch_en`.
- States (`mpmc11_arb_state_t`): ARB_IDLE, ARB_OFFER, ARB_BUSY.
- Arbitration event occurs when `(state==ARB_IDLE || state==ARB_BUSY) && select_next && |E`. On the event:
  - Winner `w` is the first set bit of E, searching from `rr_ptr+1` upward modulo NCH.
  - Same cycle: `ch_rd[w]=1`.
  - Registered on the edge: `fifo_out<=ch_req[w]`, `fifo_v<=1`, `gnt_ch<=w`, `rr_ptr<=w`, state ARB_OFFER.
- ARB_IDLE:
  - No event → stay.
  - `select_next` low → stay; this covers the state machine busy on a non-arbitrated cycle.
- ARB_OFFER:
  - `fifo_v=1`.
  - `select_next` low (state machine left IDLE) → ARB_BUSY, `fifo_v<=0`.
  - Otherwise hold. This covers calibration incomplete, `rst_busy`, etc.
  - No pop occurs in ARB_OFFER.
- ARB_BUSY:
  - `fifo_v=0`; `fifo_out` held unchanged because the state machine reads it through PRESET3 and the READ/WRITE states.
  - `select_next` high with E empty → ARB_IDLE.
  - `select_next` high with E non-empty → arbitration event; this is back-to-back service.
- `busy = (state != ARB_IDLE)`.
- `ch_rd` is combinational from registered state plus `ch_v`, `ch_en`, `select_next`. At most one bit is ever set.
- `ch_en` deasserting for the channel held in ARB_OFFER/ARB_BUSY does not cancel the held command.
- Reset values: state ARB_IDLE, `fifo_v=0`, `fifo_out='0`, `ch_rd=0`, `gnt_ch=0`, `busy=0`, `rr_ptr=NCH-1` so channel 0 wins first.
- Reset asserted mid-operation clears everything immediately. A popped-but-unserviced command is discarded.

## Timing
- Pop-to-valid latency: 1 clock. `ch_rd` occurs in cycle N; `fifo_v` is high from cycle N+1.
- Minimum command spacing is set by the state machine. No arbiter bubble is added when `select_next` rises with E non-empty; arbitration happens in that same cycle.
- Fairness: with all channels continuously eligible, grants rotate 0,1,…,NCH-1,0. Any eligible channel is granted within NCH arbitration events.
- `rr_ptr` wrap: after `w==NCH-1`, the search starts at 0.
- If the only eligible channel is `rr_ptr`, it wins again.

## Configuration
- `MPMC11_ARB_PRIO0_EN` defined:
  - Channel 0 is high priority. If `E[0]`, it wins every arbitration event.
  - `rr_ptr` is not updated on a channel-0 win.
  - Channels 1..NCH-1 round-robin among themselves when `E[0]=0`.
- Undefined: pure round-robin over all NCH channels, as above.

## Structure
- `mpmc11_pkg` holds:
  - `mpmc11_arb_state_t` (ARB_IDLE, ARB_OFFER, ARB_BUSY)
  - `MPMC11_NCH` default channel-count constant
- `fta_cmd_request256_t` comes from `fta_bus_pkg`, unchanged.
- Sub-module `mpmc11_rr_pick`:
  - Combinational rotate/priority encoder.
  - Inputs: `req[NCH]`, `ptr[CHW]`.
  - Outputs: `gnt_oh[NCH]`, `gnt_idx[CHW]`, `any`.
  - Instantiated once; also used for the channels 1..NCH-1 search under the macro.

## Test plan
- Reset: hold `rst_n=0` with `ch_v=8'hFF` → `ch_rd=0`, `fifo_v=0`, `gnt_ch=0`. After release with `select_next=1` → first `ch_rd=8'h01`.
- Single request: `ch_v=8'h08`, `select_next=1` → `ch_rd=8'h08` for one cycle; next cycle `fifo_v=1`, `gnt_ch=3`, `fifo_out` equals `ch_req[3]`.
- Hold: stall `select_next=1` for 20 cycles after grant, with no departure from IDLE → `fifo_v` stays 1, no further `ch_rd`. Drop `select_next` → `fifo_v=0` next cycle; `fifo_out` unchanged while `select_next=0`.
- Rotation: `ch_v=8'hFF`, state machine model with 5-cycle service → grant order 0..7,0. `ch_en=8'hFB` → channel 2 is never granted.
- Back-to-back: `select_next` rises with `ch_v=8'h30` → `ch_rd` is asserted in the same cycle. With `MPMC11_ARB_PRIO0_EN` and `ch_v=8'hFF` held → channel 0 wins every event.
- Mid-op reset: assert `rst_n=0` asynchronously while in ARB_BUSY → `fifo_v`, `busy`, `ch_rd` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// ============================================================================
// fta_bus_pkg : FTA bus command request type shared by mpmc11 channel logic
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fta_bus_pkg;

  typedef struct packed {
    logic         cyc;
    logic         we;
    logic [7:0]   cmd;
    logic [7:0]   blen;
    logic [15:0]  tid;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] data;
  } fta_cmd_request256_t;

endpackage : fta_bus_pkg

`default_nettype wire

// File: rtl/mpmc11_pkg.sv
// ============================================================================
// mpmc11_pkg : shared types and constants for the mpmc11 channel arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mpmc11_pkg;

  localparam int MPMC11_NCH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_BUSY  = 2'd2
  } mpmc11_arb_state_t;

endpackage : mpmc11_pkg

`default_nettype wire

// File: rtl/mpmc11_rr_pick.sv
// ============================================================================
// mpmc11_rr_pick : combinational round-robin pick, first request after ptr
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mpmc11_rr_pick #(
  parameter int NCH = 8,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt_oh,
  output logic [CHW-1:0] gnt_idx,
  output logic           any
);

  logic [CHW-1:0] idx;

  // Offsets 1..NCH visit every channel once, ending on ptr itself.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CHW'((int'(ptr) + i) % NCH);
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt_idx      = idx;
        gnt_oh[idx]  = 1'b1;
      end
    end
  end

endmodule : mpmc11_rr_pick

`default_nettype wire

// File: rtl/mpmc11_chan_arbiter_fta.sv
// ============================================================================
// mpmc11_chan_arbiter_fta : round-robin pop/hold arbiter for NCH FTA channels
// Option macro MPMC11_ARB_PRIO0_EN : channel 0 strict priority over the rest
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mpmc11_chan_arbiter_fta
  import mpmc11_pkg::*;
  import fta_bus_pkg::*;
#(
  parameter int NCH = MPMC11_NCH,
  parameter int CHW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      ch_v,
  input  fta_cmd_request256_t ch_req [NCH],
  input  logic [NCH-1:0]      ch_en,
  output logic [NCH-1:0]      ch_rd,
  input  logic                select_next,
  output fta_cmd_request256_t fifo_out,
  output logic                fifo_v,
  output logic [CHW-1:0]      gnt_ch,
  output logic                busy
);

  mpmc11_arb_state_t   state_q, state_d;
  fta_cmd_request256_t fifo_out_q, fifo_out_d;
  logic                fifo_v_q, fifo_v_d;
  logic [CHW-1:0]      gnt_ch_q, gnt_ch_d;
  logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0]      elig;
  logic [NCH-1:0]      pick_req;
  logic [NCH-1:0]      pick_oh;
  logic [CHW-1:0]      pick_idx;
  logic                pick_any;
  logic [NCH-1:0]      win_oh;
  logic [CHW-1:0]      win_idx;
  logic                win_any;
  logic                rr_upd;
  logic                arb_ev;

  assign elig = ch_v & ch_en;

`ifdef MPMC11_ARB_PRIO0_EN
  // Channel 0 is removed from the rotating search and overrides it when eligible.
  assign pick_req = {elig[NCH-1:1], 1'b0};
  assign win_any  = elig[0] | pick_any;
  assign win_idx  = elig[0] ? '0 : pick_idx;
  assign win_oh   = elig[0] ? {{(NCH-1){1'b0}}, 1'b1} : pick_oh;
  assign rr_upd   = ~elig[0];
`else
  assign pick_req = elig;
  assign win_any  = pick_any;
  assign win_idx  = pick_idx;
  assign win_oh   = pick_oh;
  assign rr_upd   = 1'b1;
`endif

  mpmc11_rr_pick #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_pick (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign arb_ev = ((state_q == ARB_IDLE) || (state_q == ARB_BUSY)) && select_next && win_any;

  // Gated by rst_n so no pop can escape while reset is held.
  assign ch_rd = (arb_ev && rst_n) ? win_oh : '0;

  always_comb begin
    state_d    = state_q;
    fifo_out_d = fifo_out_q;
    fifo_v_d   = fifo_v_q;
    gnt_ch_d   = gnt_ch_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_ev) begin
          state_d = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (!select_next) begin
          state_d  = ARB_BUSY;
          fifo_v_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (select_next) begin
          state_d = arb_ev ? ARB_OFFER : ARB_IDLE;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        fifo_v_d = 1'b0;
      end
    endcase
    if (arb_ev) begin
      fifo_out_d = ch_req[win_idx];
      fifo_v_d   = 1'b1;
      gnt_ch_d   = win_idx;
      if (rr_upd) begin
        rr_ptr_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      fifo_out_q <= '0;
      fifo_v_q   <= 1'b0;
      gnt_ch_q   <= '0;
      rr_ptr_q   <= CHW'(NCH - 1);
    end else begin
      state_q    <= state_d;
      fifo_out_q <= fifo_out_d;
      fifo_v_q   <= fifo_v_d;
      gnt_ch_q   <= gnt_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign fifo_out = fifo_out_q;
  assign fifo_v   = fifo_v_q;
  assign gnt_ch   = gnt_ch_q;
  assign busy     = (state_q != ARB_IDLE);

endmodule : mpmc11_chan_arbiter_fta

`default_nettype wire

// File: tb/tb_mpmc11_chan_arbiter_fta.sv
// ============================================================================
// tb_mpmc11_chan_arbiter_fta : scoreboard bench for mpmc11_chan_arbiter_fta
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mpmc11_chan_arbiter_fta;
  import fta_bus_pkg::*;

  localparam int NCH = 8;
  localparam int CHW = 3;
  localparam int SVC = 5;

  typedef struct {
    int                  ch;
    fta_cmd_request256_t req;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      ch_v;
  fta_cmd_request256_t ch_req [NCH];
  logic [NCH-1:0]      ch_en;
  logic [NCH-1:0]      ch_rd;
  logic                select_next;
  fta_cmd_request256_t fifo_out;
  logic                fifo_v;
  logic [CHW-1:0]      gnt_ch;
  logic                busy;

  exp_t exp_q[$];
  int   seq [NCH];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic fifo_v_prev = 1'b0;

  mpmc11_chan_arbiter_fta #(
    .NCH (NCH),
    .CHW (CHW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_v        (ch_v),
    .ch_req      (ch_req),
    .ch_en       (ch_en),
    .ch_rd       (ch_rd),
    .select_next (select_next),
    .fifo_out    (fifo_out),
    .fifo_v      (fifo_v),
    .gnt_ch      (gnt_ch),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fta_cmd_request256_t mk_req(input int ch, input int s);
    fta_cmd_request256_t r;
    r      = '0;
    r.cyc  = 1'b1;
    r.we   = s[0];
    r.cmd  = 8'(ch * 16 + s);
    r.blen = 8'(s);
    r.tid  = 16'(ch * 256 + s);
    r.sel  = 32'hFFFF_FFFF;
    r.adr  = 32'h4000_0000 | 32'(ch << 20) | 32'(s << 5);
    r.data = {8{32'(ch * 1000 + s + 7)}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_req(input string name, input fta_cmd_request256_t act,
                         input fta_cmd_request256_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new offer on fifo_v retires one expected grant.
  always @(negedge clk) begin
    if (fifo_v === 1'b1 && fifo_v_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_offer", 64'(gnt_ch), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("gnt_ch", 64'(gnt_ch), 64'(e.ch));
        chk_req("fifo_out", fifo_out, e.req);
      end
    end
    fifo_v_prev = fifo_v;
  end

  // One state-machine transaction: select_next high, pop, depart IDLE, serve.
  task automatic grant(input int ch);
    exp_t e;
    select_next = 1'b1;
    #1;
    chk("ch_rd_grant", 64'(ch_rd), 64'd1 << ch);
    e.ch  = ch;
    e.req = ch_req[ch];
    exp_q.push_back(e);
    @(negedge clk);
    chk("busy_offer", 64'(busy), 64'd1);
    seq[ch]++;
    ch_req[ch]  = mk_req(ch, seq[ch]);
    select_next = 1'b0;
    repeat (SVC) begin
      @(negedge clk);
      chk("ch_rd_service", 64'(ch_rd), 64'd0);
    end
  endtask

  task automatic go_idle();
    ch_v        = '0;
    select_next = 1'b1;
    @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("fifo_v_idle", 64'(fifo_v), 64'd0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ch_v        = '0;
    select_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fta_cmd_request256_t held;
    for (int i = 0; i < NCH; i++) begin
      seq[i]    = 0;
      ch_req[i] = mk_req(i, 0);
    end
    rst_n       = 1'b0;
    ch_v        = 8'hFF;
    ch_en       = 8'hFF;
    select_next = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values with all channels requesting
    chk("rst_ch_rd", 64'(ch_rd), 64'd0);
    chk("rst_fifo_v", 64'(fifo_v), 64'd0);
    chk("rst_gnt_ch", 64'(gnt_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_req("rst_fifo_out", fifo_out, '0);

    rst_n = 1'b1;
    grant(0);
    go_idle();

    // Single request and hold while the state machine stays in IDLE
    ch_v        = 8'h08;
    select_next = 1'b1;
    #1;
    chk("single_ch_rd", 64'(ch_rd), 64'h08);
    begin
      exp_t e;
      e.ch  = 3;
      e.req = ch_req[3];
      exp_q.push_back(e);
      held = ch_req[3];
    end
    @(negedge clk);
    seq[3]++;
    ch_req[3] = mk_req(3, seq[3]);
    repeat (20) begin
      chk("hold_fifo_v", 64'(fifo_v), 64'd1);
      chk("hold_ch_rd", 64'(ch_rd), 64'd0);
      @(negedge clk);
    end
    select_next = 1'b0;
    @(negedge clk);
    chk("drop_fifo_v", 64'(fifo_v), 64'd0);
    chk("drop_busy", 64'(busy), 64'd1);
    repeat (3) begin
      chk_req("busy_fifo_out_held", fifo_out, held);
      @(negedge clk);
    end
    go_idle();

`ifndef MPMC11_ARB_PRIO0_EN
    // Full rotation from a fresh pointer, then channel 2 disabled
    do_reset();
    ch_v  = 8'hFF;
    ch_en = 8'hFF;
    for (int i = 0; i < NCH; i++) grant(i);
    grant(0);
    ch_en = 8'hFB;
    grant(1); grant(3); grant(4); grant(5); grant(6); grant(7); grant(0); grant(1);
    // Back-to-back service from BUSY and pointer-only-eligible rewin
    ch_en = 8'hFF;
    ch_v  = 8'h30;
    grant(4); grant(5); grant(4);
    ch_v  = 8'h20;
    grant(5); grant(5);
    go_idle();
`else
    do_reset();
    ch_v  = 8'hFF;
    ch_en = 8'hFF;
    grant(0); grant(0); grant(0);
    ch_v = 8'hFE;
    grant(1); grant(2);
    ch_v = 8'hFF;
    grant(0);
    ch_v = 8'hFE;
    grant(3);
    ch_v = 8'h30;
    grant(4); grant(5);
    go_idle();
`endif

    // Asynchronous reset while BUSY with a pop pending
    do_reset();
    ch_v  = 8'hFF;
    ch_en = 8'hFF;
    grant(0);
    select_next = 1'b1;
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_ch_rd_nz", 64'(ch_rd != '0), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fifo_v", 64'(fifo_v), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_ch_rd", 64'(ch_rd), 64'd0);
    @(negedge clk);
    select_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    grant(0);
    go_idle();

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mpmc11_chan_arbiter_fta

`default_nettype wire
